// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK serializer, modulator and deserializer.
// Holds the serializer state encoding and the default framing constants.
package bpsk_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2
    } ser_state_t;

    localparam int         PACKET_SIZE   = 32;
    localparam int         PREAMBLE_BITS = 8;
    localparam logic [7:0] PREAMBLE_WORD = 8'b1010_1010;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_shifter.sv
// Loadable shift register that presents the next outgoing bit on head.
// A load and a shift in the same cycle store the loaded word already shifted once.
module bit_shifter #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             head,
    output logic             din_head
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] next_s;

    assign head     = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
    assign din_head = MSB_FIRST ? din[WIDTH-1] : din[0];

    // next register contents from load/shift controls
    always_comb begin
        src_s  = load ? din : q_r;
        next_s = src_s;
        if (shift) begin
            if (MSB_FIRST) begin
                next_s = {src_s[WIDTH-2:0], 1'b0};
            end else begin
                next_s = {1'b0, src_s[WIDTH-1:1]};
            end
        end else begin
            next_s = src_s;
        end
    end

    // shift register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= next_s;
        end
    end

endmodule

// File: rtl/bpsk_frame_serializer.sv
// Frames packets with a preamble and serialises them one bit per bit_tick.
// A one-deep holding buffer lets the next packet follow without an idle gap.
module bpsk_frame_serializer
    import bpsk_pkg::*;
#(
    parameter int PACKET_WIDTH = PACKET_SIZE,
    parameter int PREAMBLE_LEN = PREAMBLE_BITS,
    parameter logic [((PREAMBLE_LEN > 0) ? PREAMBLE_LEN : 1)-1:0] PREAMBLE_PATTERN = PREAMBLE_WORD,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] sys_packet,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    bit_tick,
    output logic                    signal_stream,
    output logic                    stream_active,
    output logic                    packet_done
);

    localparam int PAT_W   = (PREAMBLE_LEN > 0) ? PREAMBLE_LEN : 1;
    localparam int CNT_W   = $clog2(max_int(PREAMBLE_LEN, PACKET_WIDTH) + 1);
    localparam bit HAS_PRE = (PREAMBLE_LEN > 0);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PACKET_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ser_state_t              state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [PACKET_WIDTH-1:0] buf_r;
    logic                    buf_full_r;
    logic                    hs_s;
    logic                    sh_load_s;
    logic                    sh_shift_s;
    logic                    sh_head_s;
    logic                    buf_head_s;
    logic                    frame_head_s;

    // Preamble index 0 is the pattern MSB.
    function automatic logic preamble_bit(input logic [CNT_W-1:0] idx);
        logic [PAT_W-1:0] sh;
        sh = PREAMBLE_PATTERN >> (PAT_W - 1 - int'(idx));
        return sh[0];
    endfunction

    assign hs_s = in_valid & in_ready;

    bit_shifter #(
        .WIDTH    (PACKET_WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load_s),
        .shift   (sh_shift_s),
        .din     (buf_r),
        .head    (sh_head_s),
        .din_head(buf_head_s)
    );

    // first bit of a new frame and the shifter controls for this tick
    always_comb begin
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        if (HAS_PRE) begin
            frame_head_s = preamble_bit({CNT_W{1'b0}});
        end else begin
            frame_head_s = buf_head_s;
        end
        if (bit_tick) begin
            case (state_r)
                S_IDLE: begin
                    sh_load_s  = buf_full_r;
                    sh_shift_s = buf_full_r & ~HAS_PRE;
                end
                S_PREAMBLE: begin
                    sh_shift_s = (cnt_r == PRE_LAST);
                end
                S_PAYLOAD: begin
                    if (cnt_r == PAY_LAST) begin
                        sh_load_s  = buf_full_r;
                        sh_shift_s = buf_full_r & ~HAS_PRE;
                    end else begin
                        sh_shift_s = 1'b1;
                    end
                end
                default: begin
                    sh_load_s  = 1'b0;
                    sh_shift_s = 1'b0;
                end
            endcase
        end else begin
            sh_load_s  = 1'b0;
            sh_shift_s = 1'b0;
        end
    end

    // framing FSM, bit counter, holding buffer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            buf_r         <= {PACKET_WIDTH{1'b0}};
            buf_full_r    <= 1'b0;
            in_ready      <= 1'b1;
            signal_stream <= IDLE_LEVEL;
            stream_active <= 1'b0;
            packet_done   <= 1'b0;
        end else begin
            packet_done <= 1'b0;

            // accept and drain are exclusive: accept needs an empty buffer
            if (hs_s) begin
                buf_r      <= sys_packet;
                buf_full_r <= 1'b1;
                in_ready   <= 1'b0;
            end else if (sh_load_s) begin
                buf_full_r <= 1'b0;
                in_ready   <= 1'b1;
            end else begin
                buf_full_r <= buf_full_r;
                in_ready   <= in_ready;
            end

            if (bit_tick) begin
                case (state_r)
                    S_IDLE: begin
                        if (buf_full_r) begin
                            signal_stream <= frame_head_s;
                            stream_active <= 1'b1;
                            cnt_r         <= CNT_ONE;
                            state_r       <= HAS_PRE ? S_PREAMBLE : S_PAYLOAD;
                        end else begin
                            signal_stream <= IDLE_LEVEL;
                            stream_active <= 1'b0;
                        end
                    end
                    S_PREAMBLE: begin
                        if (cnt_r == PRE_LAST) begin
                            signal_stream <= sh_head_s;
                            cnt_r         <= CNT_ONE;
                            state_r       <= S_PAYLOAD;
                        end else begin
                            signal_stream <= preamble_bit(cnt_r);
                            cnt_r         <= cnt_r + CNT_ONE;
                        end
                    end
                    S_PAYLOAD: begin
                        if (cnt_r == PAY_LAST) begin
                            packet_done <= 1'b1;
                            if (buf_full_r) begin
                                signal_stream <= frame_head_s;
                                cnt_r         <= CNT_ONE;
                                state_r       <= HAS_PRE ? S_PREAMBLE : S_PAYLOAD;
                            end else begin
                                signal_stream <= IDLE_LEVEL;
                                stream_active <= 1'b0;
                                cnt_r         <= {CNT_W{1'b0}};
                                state_r       <= S_IDLE;
                            end
                        end else begin
                            signal_stream <= sh_head_s;
                            cnt_r         <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        signal_stream <= IDLE_LEVEL;
                        stream_active <= 1'b0;
                        cnt_r         <= {CNT_W{1'b0}};
                        state_r       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
